// File: rtl/clk_div_multi.sv
// clk_div_multi -- multi-channel programmable clock divider.
//
// Each channel divides clk by a runtime-loadable integer D (1..2^WIDTH-1),
// producing a 50%-duty clkout and a one-cycle tick at the start of every
// divided period. New divisors are held pending and only take effect at a
// period boundary (counter wrap, enable rise or sync), so outputs never glitch.
//
// Optional feature: define CLKDIV_SYNC_EN to add the sync_in port, which
// restarts every enabled channel at cnt=0 in the same cycle.
//
// Ports:
//   clk       in   system clock (both edges used)
//   rst       in   synchronous reset, active-high
//   sync_in   in   (CLKDIV_SYNC_EN only) phase-align all enabled channels
//   en        in   [NCH]   per-channel run enable
//   div_load  in   one-cycle strobe: write div_val to channel div_ch
//   div_ch    in   [CW]    target channel
//   div_val   in   [WIDTH] new divisor
//   div_ack   out  load accepted (one cycle after div_load)
//   div_err   out  load rejected (div_val==0 or div_ch>=NCH)
//   clkout    out  [NCH]   divided clocks
//   tick      out  [NCH]   one-cycle pulse aligned with cnt==0

// One divider channel.
module clk_div_multi_ch #(
    parameter int WIDTH   = 16,
    parameter int DEF_DIV = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sync,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_val,
    output logic             clkout,
    output logic             tick
);
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic             pvld_q, pvld_d;
    logic             en_q;
    logic             p_q, p_d;
    logic             n_q, n_d;
    logic             tick_q, tick_d;
    logic             run, start, bnd, apply;

    always_comb begin
        run    = en & en_q;
        start  = en & ~en_q;
        // Period boundary of a running channel: natural wrap or forced sync.
        bnd    = run & (sync | (cnt_q == div_q - WIDTH'(1)));
        apply  = (start | bnd) & pvld_q;
        div_d  = apply ? pend_q : div_q;
        // Apply consumes the old pending value first; a load in the same
        // cycle then re-arms pending for the following boundary.
        pend_d = pend_q;
        pvld_d = pvld_q & ~apply;
        if (ld) begin
            pend_d = ld_val;
            pvld_d = 1'b1;
        end
        cnt_d  = (run & ~bnd) ? cnt_q + WIDTH'(1) : '0;
        // Phase tracks the counter value of the coming cycle.
        p_d    = en & (cnt_d >= (div_d >> 1));
        tick_d = bnd | (start & (sync | (div_d == WIDTH'(1))));
        // Negedge copy of the phase; ANDed with p it delays the rising edge
        // of odd divisors by half a clk period for exact 50% duty.
        n_d    = en_q & (cnt_q >= (div_q >> 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            div_q  <= WIDTH'(DEF_DIV);
            pend_q <= '0;
            pvld_q <= 1'b0;
            en_q   <= 1'b0;
            p_q    <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            div_q  <= div_d;
            pend_q <= pend_d;
            pvld_q <= pvld_d;
            en_q   <= en;
            p_q    <= p_d;
            tick_q <= tick_d;
        end
    end

    always_ff @(negedge clk) begin
        if (rst) n_q <= 1'b0;
        else     n_q <= n_d;
    end

    always_comb begin
        if (div_q == WIDTH'(1))  clkout = clk & en_q;
        else if (div_q[0])       clkout = p_q & n_q;
        else                     clkout = p_q;
    end

    assign tick = tick_q;
endmodule

module clk_div_multi #(
    parameter  int NCH     = 4,
    parameter  int WIDTH   = 16,
    parameter  int DEF_DIV = 5,
    localparam int CW      = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             rst,
`ifdef CLKDIV_SYNC_EN
    input  logic             sync_in,
`endif
    input  logic [NCH-1:0]   en,
    input  logic             div_load,
    input  logic [CW-1:0]    div_ch,
    input  logic [WIDTH-1:0] div_val,
    output logic             div_ack,
    output logic             div_err,
    output logic [NCH-1:0]   clkout,
    output logic [NCH-1:0]   tick
);
    localparam logic [CW:0] NCH_L = (CW+1)'(NCH);

    logic           ack_q, ack_d;
    logic           err_q, err_d;
    logic           ld_ok;
    logic           sync;
    logic [NCH-1:0] ld;

`ifdef CLKDIV_SYNC_EN
    assign sync = sync_in;
`else
    assign sync = 1'b0;
`endif

    always_comb begin
        ld_ok = (div_val != '0) && ({1'b0, div_ch} < NCH_L);
        ack_d = div_load & ld_ok;
        err_d = div_load & ~ld_ok;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            ack_q <= ack_d;
            err_q <= err_d;
        end
    end

    assign div_ack = ack_q;
    assign div_err = err_q;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        assign ld[i] = ack_d & (div_ch == CW'(i));
        clk_div_multi_ch #(
            .WIDTH   (WIDTH),
            .DEF_DIV (DEF_DIV)
        ) u_ch (
            .clk    (clk),
            .rst    (rst),
            .en     (en[i]),
            .sync   (sync),
            .ld     (ld[i]),
            .ld_val (div_val),
            .clkout (clkout[i]),
            .tick   (tick[i])
        );
    end
endmodule

// File: tb/tb_clk_div_multi.sv
`timescale 1ns/1ps
module tb_clk_div_multi;
    localparam int NCH   = 3;
    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [NCH-1:0]   en;
    logic             div_load;
    logic [1:0]       div_ch;
    logic [WIDTH-1:0] div_val;
    logic             div_ack, div_err;
    logic [NCH-1:0]   clkout, tick;
`ifdef CLKDIV_SYNC_EN
    logic             sync_in;
`endif

    always #5 clk = ~clk;

    clk_div_multi #(.NCH(NCH), .WIDTH(WIDTH), .DEF_DIV(5)) dut (
        .clk      (clk),
        .rst      (rst),
`ifdef CLKDIV_SYNC_EN
        .sync_in  (sync_in),
`endif
        .en       (en),
        .div_load (div_load),
        .div_ch   (div_ch),
        .div_val  (div_val),
        .div_ack  (div_ack),
        .div_err  (div_err),
        .clkout   (clkout),
        .tick     (tick)
    );

    int n_chk  = 0;
    int n_fail = 0;
    string tname;

    // Per-cycle samples: first half (after posedge) and second half (after negedge).
    logic [NCH-1:0] co_a, co_b, tk_s;
    logic           ack_s, err_s;

    // Scoreboard: per channel {tick, clkout 1st half, clkout 2nd half}; plus {ack, err}.
    logic [2:0] exp_q [NCH][$];
    logic [1:0] ae_q [$];

    task automatic step();
        @(posedge clk); #2;
        co_a  = clkout;
        tk_s  = tick;
        ack_s = div_ack;
        err_s = div_err;
        @(negedge clk); #2;
        co_b  = clkout;
    endtask

    // Ideal waveform of one period of divisor d: high for the last d half-cycles
    // (d==1: clkout follows clk), tick on the first cycle unless it is the
    // very first period after an enable rise.
    task automatic push_period(int ch, int d, bit first);
        for (int j = 0; j < d; j++) begin
            logic t, a, b;
            t = (d == 1) || (j == 0 && !first);
            a = (d == 1) ? 1'b1 : (2*j >= d);
            b = (d == 1) ? 1'b0 : (2*j+1 >= d);
            exp_q[ch].push_back({t, a, b});
        end
    endtask

    task automatic push_idle(int ch, int n);
        for (int j = 0; j < n; j++) exp_q[ch].push_back(3'b000);
    endtask

    function automatic bit busy();
        for (int c = 0; c < NCH; c++) if (exp_q[c].size() != 0) return 1'b1;
        return ae_q.size() != 0;
    endfunction

    // Advance n cycles (n==0: until the scoreboard drains) popping expectations.
    task automatic run(int n);
        int k;
        k = 0;
        while ((n > 0) ? (k < n) : busy()) begin
            if (k >= 400) begin
                n_chk++; n_fail++;
                $display("FAIL %s: scoreboard not drained after %0d cycles", tname, k);
                break;
            end
            step();
            k++;
            if (ae_q.size() != 0) begin
                logic [1:0] e;
                e = ae_q.pop_front();
                n_chk++;
                if ({ack_s, err_s} !== e) begin
                    n_fail++;
                    $display("FAIL %s ack/err cyc %0d: got %b want %b", tname, k, {ack_s, err_s}, e);
                end
            end
            for (int c = 0; c < NCH; c++) begin
                if (exp_q[c].size() != 0) begin
                    logic [2:0] e, g;
                    e = exp_q[c].pop_front();
                    g = {tk_s[c], co_a[c], co_b[c]};
                    n_chk++;
                    if (g !== e) begin
                        n_fail++;
                        $display("FAIL %s ch%0d cyc %0d tick/hi1/hi2: got %b want %b", tname, c, k, g, e);
                    end
                end
            end
        end
    endtask

    task automatic load_pulse(int ch, int val, bit a, bit e);
        div_load = 1'b1;
        div_ch   = 2'(ch);
        div_val  = WIDTH'(val);
        ae_q.push_back({a, e});
        run(1);
        div_load = 1'b0;
        ae_q.push_back(2'b00);
        run(1);
    endtask

    task automatic test_reset();
        tname = "reset";
        rst = 1'b1; en = '0; div_load = 1'b0; div_ch = '0; div_val = '0;
`ifdef CLKDIV_SYNC_EN
        sync_in = 1'b0;
`endif
        repeat (3) step();
        n_chk++;
        if ({co_a, co_b, tk_s, ack_s, err_s} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got %b want 0", {co_a, co_b, tk_s, ack_s, err_s});
        end
        tname = "def_div5";
        rst = 1'b0; en = 3'b001;
        push_period(0, 5, 1); push_period(0, 5, 0); push_period(0, 5, 0);
        push_idle(1, 15); push_idle(2, 15);
        run(0);
    endtask

    task automatic test_load_ack();
        tname = "load_ack";
        en = 3'b011;
        push_period(1, 5, 1); push_period(1, 4, 0); push_period(1, 4, 0);
        run(2);
        load_pulse(1, 4, 1'b1, 1'b0);
        run(0);
    endtask

    task automatic test_load_err();
        tname = "load_err";
        en = 3'b111;
        push_period(2, 5, 1); push_period(2, 5, 0); push_period(2, 5, 0);
        run(1);
        load_pulse(2, 0, 1'b0, 1'b1);
        load_pulse(3, 7, 1'b0, 1'b1);
        run(0);
    endtask

    task automatic test_div1();
        tname = "div1";
        en = 3'b011;
        run(1);
        n_chk++;
        if ({tk_s[2], co_a[2], co_b[2]} !== 3'b000) begin
            n_fail++;
            $display("FAIL disable_ch2: got %b want 000", {tk_s[2], co_a[2], co_b[2]});
        end
        load_pulse(2, 1, 1'b1, 1'b0);
        en = 3'b111;
        for (int i = 0; i < 6; i++) push_period(2, 1, 1);
        run(0);
        en = 3'b011;
        push_idle(2, 2);
        run(0);
    endtask

    task automatic test_last_wins();
        tname = "last_wins";
        en = 3'b010;
        run(1);
        en = 3'b011;
        push_period(0, 5, 1); push_period(0, 8, 0); push_period(0, 8, 0);
        push_period(0, 3, 0); push_period(0, 3, 0);
        run(1);
        load_pulse(0, 6, 1'b1, 1'b0);
        load_pulse(0, 8, 1'b1, 1'b0);
        run(8);
        load_pulse(0, 3, 1'b1, 1'b0);  // sampled on the wrap edge
        run(0);
    endtask

    task automatic test_rst_mid();
        tname = "rst_mid";
        en = 3'b111;
        run(3);
        load_pulse(1, 7, 1'b1, 1'b0);
        rst = 1'b1; en = 3'b010;
        step(); step();
        n_chk++;
        if ({co_a, co_b, tk_s, ack_s, err_s} !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_outputs: got %b want 0", {co_a, co_b, tk_s, ack_s, err_s});
        end
        rst = 1'b0;
        push_period(1, 5, 1); push_period(1, 5, 0);
        push_idle(0, 10); push_idle(2, 10);
        run(0);
    endtask

`ifdef CLKDIV_SYNC_EN
    task automatic test_sync();
        tname = "sync";
        en = 3'b000;
        run(1);
        load_pulse(0, 3, 1'b1, 1'b0);
        load_pulse(1, 7, 1'b1, 1'b0);
        en = 3'b001;
        run(2);
        en = 3'b011;
        run(4);
        sync_in = 1'b1;
        push_period(0, 3, 0); push_period(0, 3, 0); push_period(0, 3, 0);
        push_period(1, 7, 0); push_period(1, 7, 0);
        push_idle(2, 14);
        run(1);
        sync_in = 1'b0;
        run(0);
    endtask
`endif

    initial begin
        test_reset();
        test_load_ack();
        test_load_err();
        test_div1();
        test_last_wins();
        test_rst_mid();
`ifdef CLKDIV_SYNC_EN
        test_sync();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule
